// File: rtl/long_to_double_if.sv
// Handshake bundle between an integer producer, the long_to_double converter
// and its downstream consumer. "master" is the side that supplies operands and
// sinks results; "slave" is the converter.
interface long_to_double_if;
    logic [63:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [63:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );
endinterface

// File: rtl/long_to_double.sv
// Signed 64-bit integer to IEEE-754 double converter.
// Multi-cycle, one conversion in flight. The magnitude is normalised one bit
// per cycle, then rounded to nearest, ties to even. The biased exponent can
// only reach 1023..1086, so overflow, denormals and NaN cannot arise.
module long_to_double (
    input  logic                clk,
    input  logic                rst,
    long_to_double_if.slave     bus
);

    typedef enum logic [2:0] {
        GET_A     = 3'd0,
        CONVERT_0 = 3'd1,
        CONVERT_1 = 3'd2,
        CONVERT_2 = 3'd3,
        ROUND     = 3'd4,
        PACK      = 3'd5,
        PUT_Z     = 3'd6
    } state_t;

    state_t             state_r;
    logic [63:0]        a_r;
    logic [63:0]        v_r;
    logic [63:0]        z_r;
    logic               z_s_r;
    logic signed [10:0] z_e_r;
    logic [52:0]        z_m_r;
    logic               guard_r;
    logic               round_bit_r;
    logic               sticky_r;
    logic               input_a_ack_r;
    logic               output_z_stb_r;
    logic [63:0]        output_z_r;

    logic               round_up_s;
    logic [10:0]        exp_field_s;

    assign bus.input_a_ack  = input_a_ack_r;
    assign bus.output_z_stb = output_z_stb_r;
    assign bus.output_z     = output_z_r;

    // Round-to-nearest-even decision from guard, round and sticky bits
    always_comb begin
        round_up_s = 1'b0;
        if (guard_r && (round_bit_r || sticky_r || z_m_r[0])) begin
            round_up_s = 1'b1;
        end else begin
            round_up_s = 1'b0;
        end
    end

    // Biased exponent field; unbiased exponent is always 0..63 here
    always_comb begin
        exp_field_s = 11'(z_e_r) + 11'd1023;
    end

    // Conversion state machine with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= GET_A;
            a_r            <= 64'd0;
            v_r            <= 64'd0;
            z_r            <= 64'd0;
            z_s_r          <= 1'b0;
            z_e_r          <= 11'sd0;
            z_m_r          <= 53'd0;
            guard_r        <= 1'b0;
            round_bit_r    <= 1'b0;
            sticky_r       <= 1'b0;
            input_a_ack_r  <= 1'b0;
            output_z_stb_r <= 1'b0;
            output_z_r     <= 64'd0;
        end else begin
            case (state_r)
                GET_A: begin
                    input_a_ack_r <= 1'b1;
                    if (input_a_ack_r && bus.input_a_stb) begin
                        a_r           <= bus.input_a;
                        input_a_ack_r <= 1'b0;
                        state_r       <= CONVERT_0;
                    end
                end
                CONVERT_0: begin
                    if (a_r == 64'd0) begin
                        // Zero is always +0 and skips normalisation
                        z_r     <= 64'd0;
                        state_r <= PUT_Z;
                    end else begin
                        // -2^63 negates to itself, which is the right magnitude
                        z_s_r   <= a_r[63];
                        v_r     <= a_r[63] ? (64'd0 - a_r) : a_r;
                        z_e_r   <= 11'sd63;
                        state_r <= CONVERT_1;
                    end
                end
                CONVERT_1: begin
                    if (!v_r[63]) begin
                        v_r   <= {v_r[62:0], 1'b0};
                        z_e_r <= z_e_r - 11'sd1;
                    end else begin
                        state_r <= CONVERT_2;
                    end
                end
                CONVERT_2: begin
                    z_m_r       <= v_r[63:11];
                    guard_r     <= v_r[10];
                    round_bit_r <= v_r[9];
                    sticky_r    <= |v_r[8:0];
                    state_r     <= ROUND;
                end
                ROUND: begin
                    if (round_up_s) begin
                        if (z_m_r == 53'h1F_FFFF_FFFF_FFFF) begin
                            // Mantissa carry-out renormalises to the next binade
                            z_m_r <= 53'h10_0000_0000_0000;
                            z_e_r <= z_e_r + 11'sd1;
                        end else begin
                            z_m_r <= z_m_r + 53'd1;
                        end
                    end
                    state_r <= PACK;
                end
                PACK: begin
                    z_r     <= {z_s_r, exp_field_s, z_m_r[51:0]};
                    state_r <= PUT_Z;
                end
                PUT_Z: begin
                    output_z_stb_r <= 1'b1;
                    output_z_r     <= z_r;
                    if (output_z_stb_r && bus.output_z_ack) begin
                        output_z_stb_r <= 1'b0;
                        state_r        <= GET_A;
                    end
                end
                default: begin
                    state_r        <= GET_A;
                    input_a_ack_r  <= 1'b0;
                    output_z_stb_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_long_to_double.sv
// Directed and randomised bench for long_to_double.
module tb_long_to_double;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    long_to_double_if bus ();

    long_to_double dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference conversion through the simulator's native int-to-real cast
    function automatic logic [63:0] ref_conv(input logic [63:0] a);
        longint li;
        real    r;
        li = a;
        r  = li;
        return $realtobits(r);
    endfunction

    // Present a and complete the input handshake; returns after the handshake edge
    task automatic send(input logic [63:0] a);
        int n;
        @(negedge clk);
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        n = 0;
        while (bus.input_a_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ack", {63'd0, bus.input_a_ack}, 64'd1);
        @(posedge clk);
        #1;
        bus.input_a_stb = 1'b0;
    endtask

    // Count cycles from the handshake edge until output_z_stb is seen
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.output_z_stb !== 1'b1 && lat < 200);
        check("out_stb", {63'd0, bus.output_z_stb}, 64'd1);
    endtask

    // Accept the current result after stall idle cycles
    task automatic take(input int stall);
        repeat (stall) @(posedge clk);
        #1;
        bus.output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.output_z_ack = 1'b0;
        check("stb_drop", {63'd0, bus.output_z_stb}, 64'd0);
    endtask

    // Full conversion with result check and optional latency check
    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] exp,
                       input int exp_lat);
        int lat;
        send(a);
        wait_out(lat);
        check(tag, bus.output_z, exp);
        if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        take(0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] z;
        string       tag;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat;
        logic [63:0] a;
        logic [63:0] hold_z;

        checks = 0;
        errors = 0;
        bus.input_a      = 64'd0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
        check("rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
        check("rst_z", bus.output_z, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency boundaries
        run("one", 64'h1, 64'h3FF0_0000_0000_0000, 69);
        run("zero", 64'h0, 64'h0, 2);

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, "minus_one"};
        vecs[1] = '{64'h8000_0000_0000_0000, 64'hC3E0_0000_0000_0000, "min_int"};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, "max_int"};
        vecs[3] = '{64'h0020_0000_0000_0001, 64'h4340_0000_0000_0000, "tie_even"};
        vecs[4] = '{64'h0020_0000_0000_0003, 64'h4340_0000_0000_0002, "tie_odd"};
        vecs[5] = '{64'h0040_0000_0000_0005, 64'h4350_0000_0000_0001, "sticky"};
        vecs[6] = '{64'd2, 64'h4000_0000_0000_0000, "two"};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hC008_0000_0000_0000, "minus_three"};
        vecs[8] = '{64'd1000, 64'h408F_4000_0000_0000, "thousand"};
        foreach (vecs[i]) run(vecs[i].tag, vecs[i].a, vecs[i].z, -1);

        // Stalled sink with an early upstream strobe carrying a decoy value
        send(64'd5);
        wait_out(lat);
        hold_z = bus.output_z;
        check("stall_val", hold_z, 64'h4014_0000_0000_0000);
        bus.input_a     = 64'hDEAD_BEEF_0000_0001;
        bus.input_a_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_stb", {63'd0, bus.output_z_stb}, 64'd1);
            check("stall_z", bus.output_z, hold_z);
            check("stall_ack", {63'd0, bus.input_a_ack}, 64'd0);
        end
        take(0);
        check("z_hold", bus.output_z, hold_z);
        run("after_early", 64'd3, 64'h4008_0000_0000_0000, -1);

        // Asynchronous reset during normalisation
        send(64'h1);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
        check("mid_rst_ack", {63'd0, bus.input_a_ack}, 64'd0);
        check("mid_rst_z", bus.output_z, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 69);

        // Asynchronous reset while the result is being presented
        send(64'd7);
        wait_out(lat);
        check("pre_rst2", bus.output_z, 64'h401C_0000_0000_0000);
        #2;
        rst = 1'b1;
        #1;
        check("put_rst_stb", {63'd0, bus.output_z_stb}, 64'd0);
        check("put_rst_z", bus.output_z, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run("post_rst2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hBFF0_0000_0000_0000, 69);

        // Random stream through a stalling sink
        for (int i = 0; i < 100; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) a = 64'd0 - a;
            send(a);
            wait_out(lat);
            check("rand", bus.output_z, ref_conv(a));
            take($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
